// File: rtl/treatment_dispatch.sv
// treatment_dispatch
// Pulls patients one at a time from an upstream priority queue and hands
// each one to the lowest-index free doctor out of two. Each doctor runs a
// down-counter loaded from the patient's priority. It reports busy and
// done, and the block keeps a saturating count of discharged patients.
// A dequeue that is never answered raises a sticky timeout flag.
module treatment_dispatch #(
  parameter int T_P3    = 8,
  parameter int T_P2    = 6,
  parameter int T_P1    = 4,
  parameter int T_P0    = 2,
  parameter int WAIT_TO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] q_count,
  output logic       deq_req,
  input  logic       pat_valid,
  input  logic [3:0] pat_in,
  output logic [1:0] doc_busy,
  output logic [3:0] doc0_pat,
  output logic [3:0] doc1_pat,
  output logic [1:0] doc_done,
  output logic [7:0] treated_count,
  output logic       to_err
);

  localparam int NUM_DOCS = 2;
  // Timer and wait-counter widths are wide enough for any sensible
  // parameter value up to 255.
  localparam int TW = 8;
  localparam int CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_reg;
  logic [CW-1:0]       wait_cnt_reg;
  logic [TW-1:0]       timer_reg [NUM_DOCS];
  logic [3:0]          pat_reg   [NUM_DOCS];

  logic [TW-1:0]       load_value;
  logic                accept;
  logic                taken;
  logic [NUM_DOCS-1:0] free;
  logic [NUM_DOCS-1:0] capture;
  logic [8:0]          treated_sum;
  logic [7:0]          treated_next;

  // A patient is only accepted while the FSM is waiting for it. Any
  // pat_valid seen in another state is dropped.
  assign accept = (state_reg == ST_WAIT) && pat_valid;

  // Treatment length is picked from the two priority bits of the patient
  // word.
  always_comb begin
    load_value = TW'(T_P0);
    case (pat_in[3:2])
      2'b11:   load_value = TW'(T_P3);
      2'b10:   load_value = TW'(T_P2);
      2'b01:   load_value = TW'(T_P1);
      default: load_value = TW'(T_P0);
    endcase
  end

  // Per-doctor status comes straight from the timer. A doctor counts as
  // busy through its final (done) cycle, so it becomes eligible again only
  // in the cycle after that.
  generate
    for (genvar gi = 0; gi < NUM_DOCS; gi++) begin : g_status
      assign free[gi]     = (timer_reg[gi] == '0);
      assign doc_busy[gi] = !free[gi];
      assign doc_done[gi] = (timer_reg[gi] == TW'(1));
    end
  endgenerate

  // Route an accepted patient to the lowest-index free doctor.
  always_comb begin
    capture = '0;
    taken   = 1'b0;
    for (int i = 0; i < NUM_DOCS; i++) begin
      if (accept && free[i] && !taken) begin
        capture[i] = 1'b1;
        taken      = 1'b1;
      end
    end
  end

  // Per-doctor treatment timer and held patient word. Reset aborts any
  // treatment in flight without producing a done pulse.
  generate
    for (genvar gi = 0; gi < NUM_DOCS; gi++) begin : g_doc
      always_ff @(posedge clk) begin
        if (rst) begin
          timer_reg[gi] <= '0;
          pat_reg[gi]   <= '0;
        end else if (capture[gi]) begin
          timer_reg[gi] <= load_value;
          pat_reg[gi]   <= pat_in;
        end else if (!free[gi]) begin
          timer_reg[gi] <= timer_reg[gi] - TW'(1);
        end
      end
    end
  endgenerate

  assign doc0_pat = pat_reg[0];
  assign doc1_pat = pat_reg[1];

  // Discharges in a cycle are the set doc_done bits. Both doctors can
  // finish together, so up to two are added at once, and the result is
  // clamped at all-ones.
  always_comb begin
    treated_sum  = {1'b0, treated_count} + 9'(doc_done[0]) + 9'(doc_done[1]);
    treated_next = treated_sum[8] ? 8'hFF : treated_sum[7:0];
  end

  // Running total of discharged patients.
  always_ff @(posedge clk) begin
    if (rst) begin
      treated_count <= '0;
    end else begin
      treated_count <= treated_next;
    end
  end

  // Request FSM. Only one dequeue can be outstanding at a time. deq_req is
  // registered and is high only in the single cycle spent in ST_REQ. Once
  // a request is issued the FSM waits for the patient even if q_count
  // drops to zero, and gives up after WAIT_TO silent cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      deq_req      <= 1'b0;
      wait_cnt_reg <= '0;
      to_err       <= 1'b0;
    end else begin
      deq_req <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if ((q_count != 4'd0) && (free != '0)) begin
            state_reg <= ST_REQ;
            deq_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          state_reg    <= ST_WAIT;
          wait_cnt_reg <= '0;
        end
        ST_WAIT: begin
          if (pat_valid) begin
            state_reg <= ST_IDLE;
          end else if (wait_cnt_reg == CW'(WAIT_TO - 1)) begin
            to_err    <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_treatment_dispatch.sv
// Directed testbench for treatment_dispatch. Inputs change 1 ns after each
// rising edge. Outputs are sampled at the same point, so each sample shows
// the registers as updated by the edge just passed.
module tb_treatment_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] q_count = 4'd0;
  logic       pat_valid = 1'b0;
  logic [3:0] pat_in = 4'd0;
  logic       deq_req;
  logic [1:0] doc_busy;
  logic [3:0] doc0_pat;
  logic [3:0] doc1_pat;
  logic [1:0] doc_done;
  logic [7:0] treated_count;
  logic       to_err;

  int checks = 0;
  int errors = 0;
  int nb;
  int nd;
  logic       deq_seen;
  logic [1:0] busy_seen;
  logic [1:0] done_seen;

  treatment_dispatch #(
    .T_P3(8), .T_P2(6), .T_P1(4), .T_P0(2), .WAIT_TO(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q_count(q_count),
    .deq_req(deq_req),
    .pat_valid(pat_valid),
    .pat_in(pat_in),
    .doc_busy(doc_busy),
    .doc0_pat(doc0_pat),
    .doc1_pat(doc1_pat),
    .doc_done(doc_done),
    .treated_count(treated_count),
    .to_err(to_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for deq_req, then answer it with pat after 'delay'
  // extra WAIT cycles. Returns at the sample just after the capture edge.
  task automatic serve(input logic [3:0] pat, input int delay);
    int n;
    n = 0;
    while (deq_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("serve_deq_seen", {31'd0, deq_req}, 32'd1);
    if (deq_req === 1'b1) begin
      tick();
      repeat (delay) tick();
      pat_valid = 1'b1;
      pat_in    = pat;
      tick();
      pat_valid = 1'b0;
      pat_in    = 4'd0;
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_deq_req",  {31'd0, deq_req}, 32'd0);
    chk("rst_doc_busy", {30'd0, doc_busy}, 32'd0);
    chk("rst_doc_done", {30'd0, doc_done}, 32'd0);
    chk("rst_doc0_pat", {28'd0, doc0_pat}, 32'd0);
    chk("rst_doc1_pat", {28'd0, doc1_pat}, 32'd0);
    chk("rst_treated",  {24'd0, treated_count}, 32'd0);
    chk("rst_to_err",   {31'd0, to_err}, 32'd0);

    // Empty queue for 20 cycles: no request, nothing busy
    deq_seen  = 1'b0;
    busy_seen = 2'b00;
    repeat (20) begin
      tick();
      deq_seen  = deq_seen | deq_req;
      busy_seen = busy_seen | doc_busy;
    end
    chk("idle_no_deq",  {31'd0, deq_seen}, 32'd0);
    chk("idle_no_busy", {30'd0, busy_seen}, 32'd0);
    chk("idle_treated", {24'd0, treated_count}, 32'd0);

    // Single priority-11 patient on doctor 0, 8 busy cycles
    q_count = 4'd1;
    tick();
    chk("b_deq_req", {31'd0, deq_req}, 32'd1);
    q_count = 4'd0;
    tick();
    chk("b_deq_one_cycle", {31'd0, deq_req}, 32'd0);
    pat_valid = 1'b1;
    pat_in    = 4'hE;
    tick();
    pat_valid = 1'b0;
    pat_in    = 4'h0;
    chk("b_doc0_pat", {28'd0, doc0_pat}, 32'hE);
    chk("b_busy_rise", {30'd0, doc_busy}, 32'h1);
    nb = 0;
    nd = 0;
    repeat (14) begin
      if (doc_busy == 2'b01) nb++;
      if (doc_done[0]) nd++;
      tick();
    end
    chk("b_busy_cycles", nb, 32'd8);
    chk("b_done_pulses", nd, 32'd1);
    chk("b_treated", {24'd0, treated_count}, 32'd1);
    chk("b_busy_fall", {30'd0, doc_busy}, 32'd0);
    chk("b_doc0_hold", {28'd0, doc0_pat}, 32'hE);

    // pat_valid while idle is ignored
    pat_valid = 1'b1;
    pat_in    = 4'hF;
    repeat (3) tick();
    pat_valid = 1'b0;
    pat_in    = 4'h0;
    chk("ign_busy", {30'd0, doc_busy}, 32'd0);
    chk("ign_doc0", {28'd0, doc0_pat}, 32'hE);
    chk("ign_doc1", {28'd0, doc1_pat}, 32'h0);

    // Two patients on two doctors; third request waits for a freed doctor
    q_count = 4'd3;
    serve(4'b0110, 0);
    chk("c_doc0_pat", {28'd0, doc0_pat}, 32'h6);
    chk("c_busy_01", {30'd0, doc_busy}, 32'h1);
    serve(4'b0001, 0);
    chk("c_doc1_pat", {28'd0, doc1_pat}, 32'h1);
    chk("c_busy_11", {30'd0, doc_busy}, 32'h3);
    chk("c_done0", {30'd0, doc_done}, 32'h1);
    tick();
    chk("c_busy_10", {30'd0, doc_busy}, 32'h2);
    chk("c_done1", {30'd0, doc_done}, 32'h2);
    chk("c_no_early_req", {31'd0, deq_req}, 32'd0);
    tick();
    chk("c_third_req", {31'd0, deq_req}, 32'd1);
    chk("c_busy_00", {30'd0, doc_busy}, 32'd0);
    chk("c_treated", {24'd0, treated_count}, 32'd3);

    // Unanswered request times out; queue empties meanwhile
    q_count = 4'd0;
    repeat (4) tick();
    chk("d_no_err_yet", {31'd0, to_err}, 32'd0);
    q_count = 4'd3;
    tick();
    chk("d_to_err", {31'd0, to_err}, 32'd1);
    chk("d_deq_low", {31'd0, deq_req}, 32'd0);
    chk("d_busy", {30'd0, doc_busy}, 32'd0);
    tick();
    chk("d_new_req", {31'd0, deq_req}, 32'd1);

    // Both doctors finish in the same cycle (8-cycle and 4-cycle
    // treatments captured four cycles apart)
    serve(4'b1100, 0);
    serve(4'b0100, 1);
    q_count = 4'd0;
    chk("e_busy_11", {30'd0, doc_busy}, 32'h3);
    chk("e_doc0_pat", {28'd0, doc0_pat}, 32'hC);
    chk("e_doc1_pat", {28'd0, doc1_pat}, 32'h4);
    tick();
    tick();
    chk("e_done_none", {30'd0, doc_done}, 32'd0);
    tick();
    chk("e_done_both", {30'd0, doc_done}, 32'h3);
    chk("e_treated_before", {24'd0, treated_count}, 32'd3);
    tick();
    chk("e_treated_plus2", {24'd0, treated_count}, 32'd5);
    chk("e_busy_clear", {30'd0, doc_busy}, 32'd0);
    chk("e_err_sticky", {31'd0, to_err}, 32'd1);

    // Reset aborts a treatment in its third busy cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("f_err_clr", {31'd0, to_err}, 32'd0);
    chk("f_cnt_clr", {24'd0, treated_count}, 32'd0);
    chk("f_pat_clr", {24'd0, doc0_pat, doc1_pat}, 32'd0);
    q_count = 4'd1;
    serve(4'b1110, 0);
    q_count = 4'd0;
    tick();
    tick();
    chk("f_busy_3rd", {30'd0, doc_busy}, 32'h1);
    rst       = 1'b1;
    q_count   = 4'd1;
    pat_valid = 1'b1;
    pat_in    = 4'hF;
    tick();
    rst       = 1'b0;
    q_count   = 4'd0;
    pat_valid = 1'b0;
    pat_in    = 4'h0;
    chk("f_busy_abort", {30'd0, doc_busy}, 32'd0);
    chk("f_deq_rst", {31'd0, deq_req}, 32'd0);
    chk("f_doc0_clr", {28'd0, doc0_pat}, 32'd0);
    done_seen = 2'b00;
    repeat (12) begin
      done_seen = done_seen | doc_done;
      tick();
    end
    chk("f_no_done", {30'd0, done_seen}, 32'd0);
    chk("f_treated", {24'd0, treated_count}, 32'd0);

    // Saturation of the discharge counter
    q_count = 4'd1;
    repeat (200) serve(4'b0000, 0);
    q_count = 4'd0;
    repeat (6) tick();
    chk("g_count_200", {24'd0, treated_count}, 32'd200);
    q_count = 4'd1;
    repeat (60) serve(4'b0000, 0);
    q_count = 4'd0;
    repeat (6) tick();
    chk("g_saturate", {24'd0, treated_count}, 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
